// File: rtl/alu_pkg.sv
// Shared types for the registered ALU: opcodes, status flags and control states.
package alu_pkg;

  typedef enum logic [2:0] {
    OP_ADD = 3'd0,
    OP_SUB = 3'd1,
    OP_AND = 3'd2,
    OP_OR  = 3'd3,
    OP_XOR = 3'd4,
    OP_SHL = 3'd5,
    OP_SHR = 3'd6,
    OP_MUL = 3'd7
  } alu_op_e;

  typedef struct packed {
    logic zero;
    logic carry;
    logic neg;
    logic ovf;
  } alu_flags_t;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_MUL  = 1'b1
  } alu_state_e;

endpackage

// File: rtl/alu_pipe_if.sv
// Operand and result handshake bundle for alu_pipe; slave is the ALU side.
interface alu_pipe_if #(
  parameter int unsigned WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in0;
  logic [WIDTH-1:0] in1;
  logic [2:0]       select;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             zero_flag;
  logic             carry_flag;
  logic             neg_flag;
  logic             ovf_flag;

  modport master (
    output in_valid, in0, in1, select, out_ready,
    input  in_ready, out_valid, result, zero_flag, carry_flag, neg_flag, ovf_flag
  );

  modport slave (
    input  in_valid, in0, in1, select, out_ready,
    output in_ready, out_valid, result, zero_flag, carry_flag, neg_flag, ovf_flag
  );
endinterface

// File: rtl/alu_mul_seq.sv
// Radix-2 shift-add multiplier, one multiplier bit per clock, WIDTH iterations.
module alu_mul_seq #(
  parameter int unsigned WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [WIDTH-1:0]   multiplicand,
  input  logic [WIDTH-1:0]   multiplier,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);
  localparam int unsigned CW = $clog2(WIDTH + 1);

  logic [2*WIDTH-1:0] acc_q, acc_d, mcand_q, mcand_d, sum;
  logic [WIDTH-1:0]   mplier_q, mplier_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               run_q, run_d;

  // product is the accumulator's next value, so the caller can capture the
  // final sum on the same edge as the last iteration
  always_comb begin
    sum      = acc_q + (mplier_q[0] ? mcand_q : '0);
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    cnt_d    = cnt_q;
    run_d    = run_q;
    done     = 1'b0;
    if (start) begin
      acc_d    = '0;
      mcand_d  = {{WIDTH{1'b0}}, multiplicand};
      mplier_d = multiplier;
      cnt_d    = '0;
      run_d    = 1'b1;
    end else if (run_q) begin
      acc_d    = sum;
      mcand_d  = mcand_q << 1;
      mplier_d = mplier_q >> 1;
      cnt_d    = cnt_q + 1'b1;
      if (cnt_q == CW'(WIDTH - 1)) begin
        done  = 1'b1;
        run_d = 1'b0;
      end
    end
    product = sum;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
      run_q    <= 1'b0;
    end else begin
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      cnt_q    <= cnt_d;
      run_q    <= run_d;
    end
  end
endmodule

// File: rtl/alu_pipe.sv
// Registered ALU with valid/ready in and out; define ALU_MUL_EN to enable the
// iterative multiplier for opcode 7 (otherwise it yields a single-cycle zero).
module alu_pipe
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic     clk,
  input  logic     rst_n,
  alu_pipe_if.slave bus,
  output logic     busy
);
  localparam int unsigned SHW = $clog2(WIDTH);

  alu_op_e          op;
  logic [SHW-1:0]   sh;
  logic             in_ready, accept;
  logic [WIDTH:0]   wide;
  logic [WIDTH-1:0] res_c, load_res;
  alu_flags_t       flg_c, load_flg;
  logic             load;

  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] result_q, result_d;
  alu_flags_t       flags_q, flags_d;

  assign op       = alu_op_e'(bus.select);
  assign sh       = bus.in1[SHW-1:0];
  assign in_ready = !busy && (!out_valid_q || bus.out_ready);
  assign accept   = bus.in_valid && in_ready;

  // Single-cycle datapath; the extra bit of wide carries carry/borrow/shift-out
  always_comb begin
    wide  = '0;
    res_c = '0;
    flg_c = '0;
    unique case (op)
      OP_ADD: begin
        wide      = {1'b0, bus.in0} + {1'b0, bus.in1};
        res_c     = wide[WIDTH-1:0];
        flg_c.carry = wide[WIDTH];
        flg_c.ovf = (bus.in0[WIDTH-1] == bus.in1[WIDTH-1]) && (res_c[WIDTH-1] != bus.in0[WIDTH-1]);
      end
      OP_SUB: begin
        wide      = {1'b0, bus.in0} - {1'b0, bus.in1};
        res_c     = wide[WIDTH-1:0];
        flg_c.carry = wide[WIDTH];
        flg_c.ovf = (bus.in0[WIDTH-1] != bus.in1[WIDTH-1]) && (res_c[WIDTH-1] != bus.in0[WIDTH-1]);
      end
      OP_AND: res_c = bus.in0 & bus.in1;
      OP_OR:  res_c = bus.in0 | bus.in1;
      OP_XOR: res_c = bus.in0 ^ bus.in1;
      OP_SHL: begin
        wide        = {1'b0, bus.in0} << sh;
        res_c       = wide[WIDTH-1:0];
        flg_c.carry = wide[WIDTH];
      end
      OP_SHR: begin
        wide        = {bus.in0, 1'b0} >> sh;
        res_c       = wide[WIDTH:1];
        flg_c.carry = wide[0];
      end
      default: res_c = '0;
    endcase
    flg_c.zero = (res_c == '0);
    flg_c.neg  = res_c[WIDTH-1];
  end

`ifdef ALU_MUL_EN
  alu_state_e         state_q, state_d;
  logic               mul_start, mul_done;
  logic [2*WIDTH-1:0] product;
  alu_flags_t         mul_flg;

  assign mul_start = accept && (op == OP_MUL);

  alu_mul_seq #(.WIDTH(WIDTH)) u_mul (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (mul_start),
    .multiplicand (bus.in0),
    .multiplier   (bus.in1),
    .done         (mul_done),
    .product      (product)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (mul_start) state_d = ST_MUL;
      ST_MUL:  if (mul_done)  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    mul_flg.zero  = (product[WIDTH-1:0] == '0);
    mul_flg.carry = |product[2*WIDTH-1:WIDTH];
    mul_flg.neg   = product[WIDTH-1];
    mul_flg.ovf   = 1'b0;
    busy          = (state_q == ST_MUL);
    load          = (accept && (op != OP_MUL)) || (busy && mul_done);
    load_res      = busy ? product[WIDTH-1:0] : res_c;
    load_flg      = busy ? mul_flg : flg_c;
  end
`else
  always_comb begin
    busy     = 1'b0;
    load     = accept;
    load_res = res_c;
    load_flg = flg_c;
  end
`endif

  // A load on the same edge as a pop replaces the result and keeps out_valid high
  always_comb begin
    out_valid_d = load || (out_valid_q && !bus.out_ready);
    result_d    = load ? load_res : result_q;
    flags_d     = load ? load_flg : flags_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      result_q    <= '0;
      flags_q     <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      result_q    <= result_d;
      flags_q     <= flags_d;
    end
  end

  assign bus.in_ready   = in_ready;
  assign bus.out_valid  = out_valid_q;
  assign bus.result     = result_q;
  assign bus.zero_flag  = flags_q.zero;
  assign bus.carry_flag = flags_q.carry;
  assign bus.neg_flag   = flags_q.neg;
  assign bus.ovf_flag   = flags_q.ovf;
endmodule

// File: tb/tb_alu_pipe.sv
// Bench for alu_pipe (WIDTH=8): directed cases with literal results, then random traffic vs a model.
module tb_alu_pipe;
  localparam int W = 8;
`ifdef ALU_MUL_EN
  localparam bit MUL_EN = 1'b1;
`else
  localparam bit MUL_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic busy;
  int   total = 0;
  int   bad = 0;

  alu_pipe_if #(.WIDTH(W)) bus ();

  alu_pipe #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus),
    .busy  (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, got running expected finished");
    $display("test done: total=%0d bad=%0d", total, bad + 1);
    $fatal(1, "watchdog");
  end

  // Model state: registered output {result, zero, carry, neg, ovf}, its valid bit,
  // and cycles left in an in-flight multiply.
  logic [11:0] m_out = '0;
  bit          m_ov = 1'b0;
  int          m_cnt = 0;
  logic [11:0] m_mulres = '0;

  function automatic logic [11:0] ref_op(input int op, input int a, input int b);
    int r, c, o, sh;
    r = 0; c = 0; o = 0;
    sh = b % W;
    case (op)
      0: begin r = (a + b) % 256; c = (a + b) / 256;
               o = int'(((a >= 128) == (b >= 128)) && ((r >= 128) != (a >= 128))); end
      1: begin r = (a - b + 256) % 256; c = int'(a < b);
               o = int'(((a >= 128) != (b >= 128)) && ((r >= 128) != (a >= 128))); end
      2: r = a & b;
      3: r = a | b;
      4: r = a ^ b;
      5: begin r = (a << sh) % 256; c = (sh == 0) ? 0 : ((a << sh) / 256) % 2; end
      6: begin r = a >> sh; c = (sh == 0) ? 0 : (a >> (sh - 1)) % 2; end
      default: if (MUL_EN) begin r = (a * b) % 256; c = int'((a * b) >= 256); end
    endcase
    return {r[7:0], r == 0, c[0], r >= 128, o[0]};
  endfunction

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [11:0] dut_out();
    return {bus.result, bus.zero_flag, bus.carry_flag, bus.neg_flag, bus.ovf_flag};
  endfunction

  // One clock: compare at negedge, drive inputs, check in_ready, advance the model.
  task automatic step(input bit v, input int op, input int a, input int b, input bit ordy,
                      output bit acc);
    bit exp_busy, exp_ir, load;
    logic [11:0] nv;
    @(negedge clk);
    exp_busy = MUL_EN && (m_cnt > 0);
    check("out_valid", 16'(bus.out_valid), 16'(m_ov));
    check("busy", 16'(busy), 16'(exp_busy));
    if (m_ov) check("out_data", 16'(dut_out()), 16'(m_out));
    bus.in_valid  = v;
    bus.select    = 3'(op);
    bus.in0       = 8'(a);
    bus.in1       = 8'(b);
    bus.out_ready = ordy;
    #1;
    exp_ir = !exp_busy && (!m_ov || ordy);
    check("in_ready", 16'(bus.in_ready), 16'(exp_ir));
    acc  = v && exp_ir;
    load = 1'b0;
    nv   = '0;
    if (m_cnt > 0) begin
      m_cnt--;
      if (m_cnt == 0) begin load = 1'b1; nv = m_mulres; end
    end else if (acc) begin
      if (MUL_EN && op == 7) begin
        m_cnt = W;
        m_mulres = ref_op(op, a, b);
      end else begin
        load = 1'b1;
        nv = ref_op(op, a, b);
      end
    end
    if (load) begin m_ov = 1'b1; m_out = nv; end
    else if (ordy) m_ov = 1'b0;
  endtask

  task automatic dir_op(input string name, input int op, input int a, input int b,
                        input logic [11:0] exp, input int exp_lat);
    bit acc;
    int n, lat;
    check({"model_", name}, 16'(ref_op(op, a, b)), 16'(exp));
    n = 0;
    acc = 1'b0;
    while (!acc && n < 20) begin step(1'b1, op, a, b, 1'b1, acc); n++; end
    check({"accept_", name}, 16'(acc), 16'd1);
    lat = 0;
    do begin
      step(1'b0, 0, 0, 0, 1'b0, acc);
      lat++;
    end while (!bus.out_valid && lat < 40);
    check({"latency_", name}, 16'(lat), 16'(exp_lat));
    check({"result_", name}, 16'(dut_out()), 16'(exp));
    step(1'b0, 0, 0, 0, 1'b1, acc);
  endtask

  initial begin
    bit acc;
    int mul_lat;
    bus.in_valid = 1'b0; bus.select = '0; bus.in0 = '0; bus.in1 = '0; bus.out_ready = 1'b1;
    mul_lat = MUL_EN ? W : 1;
    repeat (3) @(posedge clk);
    #1;
    check("reset_out_valid", 16'(bus.out_valid), 16'd0);
    check("reset_data", 16'(dut_out()), 16'd0);
    check("reset_busy", 16'(busy), 16'd0);
    @(negedge clk);
    rst_n = 1'b1;

    dir_op("add_ff_01", 0, 'hFF, 'h01, {8'h00, 4'b1100}, 1);
    dir_op("add_7f_01", 0, 'h7F, 'h01, {8'h80, 4'b0011}, 1);
    dir_op("sub_10_20", 1, 'h10, 'h20, {8'hF0, 4'b0110}, 1);
    dir_op("shl_81_1",  5, 'h81, 'h01, {8'h02, 4'b0100}, 1);
    dir_op("shr_01_0",  6, 'h01, 'h00, {8'h01, 4'b0000}, 1);
    dir_op("shl_hi_ign", 5, 'h03, 'hF9, {8'h06, 4'b0000}, 1);
    dir_op("shr_80_7",  6, 'h80, 'h07, {8'h01, 4'b0000}, 1);
    if (MUL_EN) begin
      dir_op("mul_10_10", 7, 'h10, 'h10, {8'h00, 4'b1100}, mul_lat);
      dir_op("mul_0f_03", 7, 'h0F, 'h03, {8'h2D, 4'b0000}, mul_lat);
    end else begin
      dir_op("mul_off_a", 7, 'h10, 'h10, {8'h00, 4'b1000}, mul_lat);
      dir_op("mul_off_b", 7, 'h0F, 'h03, {8'h00, 4'b1000}, mul_lat);
    end

    // Back-to-back logic ops, then two cycles of backpressure
    step(1'b1, 2, 'hF0, 'h3C, 1'b1, acc); check("b2b_and", 16'(acc), 16'd1);
    step(1'b1, 3, 'hF0, 'h3C, 1'b1, acc); check("b2b_or",  16'(acc), 16'd1);
    step(1'b1, 4, 'hF0, 'h3C, 1'b1, acc); check("b2b_xor", 16'(acc), 16'd1);
    step(1'b1, 0, 'h01, 'h01, 1'b0, acc); check("bp_stall1", 16'(acc), 16'd0);
    step(1'b1, 0, 'h01, 'h01, 1'b0, acc); check("bp_stall2", 16'(acc), 16'd0);
    check("bp_hold", 16'(dut_out()), 16'({8'hCC, 4'b0010}));
    step(1'b0, 0, 0, 0, 1'b1, acc);

    // Reset three cycles into a multiply
    step(1'b1, 7, 'h5A, 'hC3, 1'b1, acc);
    repeat (3) step(1'b0, 0, 0, 0, 1'b0, acc);
    rst_n = 1'b0;
    #1;
    check("midreset_out_valid", 16'(bus.out_valid), 16'd0);
    check("midreset_busy", 16'(busy), 16'd0);
    check("midreset_data", 16'(dut_out()), 16'd0);
    m_ov = 1'b0; m_out = '0; m_cnt = 0;
    #1 rst_n = 1'b1;
    dir_op("post_reset_add", 0, 'h12, 'h34, {8'h46, 4'b0000}, 1);

    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(0, 3) != 0, int'($urandom_range(0, 7)), int'($urandom_range(0, 255)),
           int'($urandom_range(0, 255)), $urandom_range(0, 3) != 0, acc);
    end
    repeat (W + 2) step(1'b0, 0, 0, 0, 1'b1, acc);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/alu_pipe.md
# alu_pipe

Parametrised, registered successor to the 8-bit combinational ALU. Takes operand pairs through a valid/ready handshake, executes one of eight operations, and presents a registered result with four status flags through a second valid/ready handshake. Single-cycle ops sustain one result per clock. MUL is an optional iterative shift-add operation. It sits between the register-file/RAM read path and the write-back path.

## Interface
- WIDTH, 8: operand and result width, ≥ 4.
- clk  in  1: sole clock, rising edge.
- rst_n  in  1: asynchronous, active-low reset.
- in_valid  in  1: operand pair and select are valid.
- in_ready  out  1: block accepts this cycle.
- in0, in1  in  WIDTH: operands.
- select  in  3: opcode, as alu_op_e.
- out_valid  out  1: result and flags are valid.
- out_ready  in  1: consumer accepts this cycle.
- result  out  WIDTH: operation result.
- zero_flag  out  1: result == 0.
- carry_flag  out  1: carry, borrow, shifted-out bit or MUL overflow.
- neg_flag  out  1: result[WIDTH-1].
- ovf_flag  out  1: signed overflow, ADD/SUB only, else 0.
- busy  out  1: MUL iteration in progress.

## Operation
- Accept: a transfer occurs on a rising edge where in_valid && in_ready.
  - in_ready = !busy && (!out_valid || out_ready).
- Opcodes:
  - 0 ADD: {carry, result} = in0 + in1, width WIDTH+1.
  - 1 SUB: result = in0 − in1 mod 2^WIDTH; carry = borrow (in0 < in1, unsigned).
  - 2 AND, 3 OR, 4 XOR: carry = 0.
  - 5 SHL / 6 SHR: logical shift of in0 by sh = in1[$clog2(WIDTH)-1:0].
    - Upper bits of in1 are ignored.
    - carry = last bit shifted out; carry = 0 when sh = 0.
  - 7 MUL: low WIDTH bits of the unsigned product; carry = 1 if the upper WIDTH bits are nonzero.
- ovf_flag:
  - ADD: operand signs equal and result sign differs.
  - SUB: operand signs differ and result sign differs from in0.
- zero_flag and neg_flag are computed from the final result for every opcode.
- State machine:
  - IDLE → MUL on accept of opcode 7.
  - MUL → IDLE after WIDTH iterations; result and flags load into the output register and out_valid sets.
  - All other opcodes stay in IDLE and load the output register directly.
- Output register holds result and flags stable while out_valid && !out_ready.
- out_valid clears on out_ready unless a new result loads on the same edge.
- Reset (any time, including mid-MUL):
  - state = IDLE, busy = 0, out_valid = 0.
  - result = 0, all flags = 0.
  - The partial product is discarded.

## Timing
- Single-cycle ops: accept on edge k → out_valid, result and flags valid after edge k.
  - With out_ready held high, one accept and one result per clock.
- Simultaneous pop and push on the same edge: the new result replaces the old one and out_valid stays 1.
- MUL: accept on edge k → busy = 1 after edge k → WIDTH iteration edges.
  - out_valid = 1 and busy = 0 after edge k+WIDTH.
  - in_ready = 0 throughout busy.
- Backpressure: while out_valid && !out_ready, in_ready = 0 and no operation starts.
- in_ready depends combinationally on out_ready; there is no other input-to-output combinational path.

## Configuration
- ALU_MUL_EN defined:
  - opcode 7 runs the iterative multiplier as above.
  - alu_mul_seq is instantiated.
- ALU_MUL_EN undefined:
  - opcode 7 is single-cycle with result = 0, zero_flag = 1 and all other flags 0.
  - busy ties to 0, no multiplier logic is present, and the state machine collapses to IDLE.

## Structure
- alu_pkg holds:
  - typedef enum logic [2:0] alu_op_e: OP_ADD … OP_MUL.
  - typedef struct alu_flags_t: zero, carry, neg, ovf.
- Sub-module alu_mul_seq (WIDTH):
  - ports: start, multiplicand, multiplier, done, product[2*WIDTH-1:0].
  - radix-2 shift-add, one bit per cycle.
  - same clk/rst_n.
- The top level holds the handshake, the state machine, the single-cycle datapath and the output register.

## Test plan
All scenarios use WIDTH = 8.
- Reset mid-MUL: assert rst_n = 0 three cycles into a MUL → out_valid = 0, busy = 0, result = 0 and flags = 0 immediately; the next accept behaves normally.
- ADD 0xFF + 0x01 → result 0x00, zero = 1, carry = 1, ovf = 0, one cycle later. ADD 0x7F + 0x01 → result 0x80, neg = 1, ovf = 1, carry = 0.
- SUB 0x10 − 0x20 → result 0xF0, carry (borrow) = 1, neg = 1. SHL 0x81 by 1 → result 0x02, carry = 1. SHR 0x01 by 0 → result 0x01, carry = 0.
- Back-to-back AND, OR, XOR with out_ready = 1 → three results on three consecutive cycles. Drop out_ready for 2 cycles → result held stable and in_ready = 0.
- MUL 0x10 × 0x10 with ALU_MUL_EN:
  - busy for 8 cycles, in_ready = 0 throughout.
  - out_valid 8 cycles after accept, result = 0x00, carry = 1, zero = 1.
  - MUL 0x0F × 0x03 → result 0x2D, carry = 0.
- Without ALU_MUL_EN: opcode 7 → result 0x00 and zero = 1 after one cycle, busy never asserted.
